// File: rtl/pwm_start_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_start_sequencer
//
// Purpose:
//   Brings a bank of NCH PWM channels up one at a time with a programmable
//   stagger. A start request in IDLE captures the packed per-channel delay
//   word and walks the channels in index order. Channel k turns on
//   delay[k]+1 cycles after channel k-1 (or after STAGGER entry for
//   channel 0). Once the last channel is on, the block sits in RUN until a
//   stop request, a trip or reset turns every channel off again.
//
// Parameters:
//   NCH    number of PWM channels sequenced
//   DLY_W  width of each incremental delay, in clk cycles
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   start_req  start request, honoured only in IDLE and only without stop_req
//   stop_req   stop request, honoured in STAGGER and RUN (and blocks a start)
//   delay      packed incremental delays, channel k at [k*DLY_W +: DLY_W]
//   trip       fault trip (PWMSEQ_TRIP_EN builds only)
//   fault_clr  fault clear (PWMSEQ_TRIP_EN builds only)
//   pwm_onoff  per-channel ON/OFF drive, 1 = ON
//   busy       high while the sequencer is in STAGGER (one cycle behind)
//   running    high while the sequencer is in RUN (one cycle behind)
//   seq_done   one-cycle pulse marking entry to RUN
//   fault      high while in FAULT; tied low without PWMSEQ_TRIP_EN
//
// Build option:
//   PWMSEQ_TRIP_EN  adds trip/fault_clr and the FAULT state. A trip in any
//                   state turns all channels off and enters FAULT at the
//                   next edge, taking priority over start and stop.
//                   FAULT is left only when fault_clr=1 and trip=0.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module pwm_start_sequencer #(
    parameter int NCH   = 4,
    parameter int DLY_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_req,
    input  logic                 stop_req,
    input  logic [NCH*DLY_W-1:0] delay,
`ifdef PWMSEQ_TRIP_EN
    input  logic                 trip,
    input  logic                 fault_clr,
`endif
    output logic [NCH-1:0]       pwm_onoff,
    output logic                 busy,
    output logic                 running,
    output logic                 seq_done,
    output logic                 fault
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef PWMSEQ_TRIP_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_STAGGER,
        S_RUN,
        S_STOP,
        S_FAULT
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_STAGGER,
        S_RUN,
        S_STOP
    } state_t;
`endif

    state_t             state;
    state_t             state_next;

    logic [DLY_W-1:0]   cnt;
    logic [DLY_W-1:0]   cnt_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [DLY_W-1:0]   snap [NCH];
    logic               snap_load;

    logic               cnt_hit;
    logic               last_ch;
    logic [NCH-1:0]     ch_mask;

    logic [NCH-1:0]     pwm_next;
    logic               busy_next;
    logic               running_next;
    logic               seq_done_next;

    // The delay of the channel currently being waited on comes from the
    // snapshot, so the live delay input cannot disturb a sequence in flight.
    assign cnt_hit = (cnt == snap[idx]);
    assign last_ch = (idx == IDX_W'(NCH - 1));

    always_comb begin
        ch_mask      = '0;
        ch_mask[idx] = 1'b1;
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                // stop wins over a simultaneous start
                if (start_req && !stop_req) begin
                    state_next = S_STAGGER;
                end
            end
            S_STAGGER: begin
                if (stop_req) begin
                    state_next = S_STOP;
                end else if (cnt_hit && last_ch) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (stop_req) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                state_next = S_IDLE;
            end
`ifdef PWMSEQ_TRIP_EN
            S_FAULT: begin
                if (fault_clr && !trip) begin
                    state_next = S_IDLE;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
`ifdef PWMSEQ_TRIP_EN
        if (trip) begin
            state_next = S_FAULT;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Output logic (values loaded into the output flops at the next edge)
    // -----------------------------------------------------------------------
    always_comb begin
        pwm_next      = '0;
        busy_next     = (state == S_STAGGER);
        running_next  = (state == S_RUN);
        // running still holds last cycle's view, so this is true only on
        // the first cycle spent in RUN
        seq_done_next = (state == S_RUN) && !running;

        // Channels only accumulate while the sequence continues; leaving
        // for STOP, IDLE or FAULT drops every channel in one edge.
        if (state_next == S_STAGGER || state_next == S_RUN) begin
            pwm_next = pwm_onoff;
            if (state == S_STAGGER && cnt_hit) begin
                pwm_next = pwm_onoff | ch_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_onoff <= '0;
            busy      <= 1'b0;
            running   <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            pwm_onoff <= pwm_next;
            busy      <= busy_next;
            running   <= running_next;
            seq_done  <= seq_done_next;
        end
    end

`ifdef PWMSEQ_TRIP_EN
    // fault follows the state being entered, so it rises together with
    // the channels dropping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault <= 1'b0;
        end else begin
            fault <= (state_next == S_FAULT);
        end
    end
`else
    assign fault = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Stagger counter, channel index and delay snapshot
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_next  = cnt;
        idx_next  = idx;
        snap_load = 1'b0;
        if (state == S_IDLE && state_next == S_STAGGER) begin
            cnt_next  = '0;
            idx_next  = '0;
            snap_load = 1'b1;
        end else if (state == S_STAGGER) begin
            if (cnt_hit) begin
                // the counter restarts before it can pass the largest
                // delay value, so it never wraps
                cnt_next = '0;
                if (!last_ch) begin
                    idx_next = idx + IDX_W'(1);
                end
            end else begin
                cnt_next = cnt + DLY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
            for (int k = 0; k < NCH; k++) begin
                snap[k] <= '0;
            end
        end else begin
            cnt <= cnt_next;
            idx <= idx_next;
            if (snap_load) begin
                for (int k = 0; k < NCH; k++) begin
                    snap[k] <= delay[k*DLY_W +: DLY_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_start_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_start_sequencer
//
// Self-checking bench for pwm_start_sequencer (NCH=4, DLY_W=8).
// The reference model describes a sequence by absolute cycle numbers: the
// cycle STAGGER begins, the cycle each channel turns on, and the cycle the
// sequence ends (stop or trip). Fault episodes are kept the same way. All
// expected outputs for a cycle are derived from those timestamps. Directed
// runs pin the model with literal cycle offsets, then randomized traffic
// runs against it.
// ---------------------------------------------------------------------------
module tb_pwm_start_sequencer;

    localparam int     NCH   = 4;
    localparam int     DLY_W = 8;
    localparam longint INF   = 64'sd1 << 40;
`ifdef PWMSEQ_TRIP_EN
    localparam bit TRIP_EN = 1'b1;
`else
    localparam bit TRIP_EN = 1'b0;
`endif

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b0;
    logic                 start_req = 1'b0;
    logic                 stop_req  = 1'b0;
    logic                 trip      = 1'b0;
    logic                 fault_clr = 1'b0;
    logic [NCH*DLY_W-1:0] delay     = '0;
    logic [NCH-1:0]       pwm_onoff;
    logic                 busy;
    logic                 running;
    logic                 seq_done;
    logic                 fault;

    always #5 clk = ~clk;

    pwm_start_sequencer #(.NCH(NCH), .DLY_W(DLY_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_req (start_req),
        .stop_req  (stop_req),
        .delay     (delay),
`ifdef PWMSEQ_TRIP_EN
        .trip      (trip),
        .fault_clr (fault_clr),
`endif
        .pwm_onoff (pwm_onoff),
        .busy      (busy),
        .running   (running),
        .seq_done  (seq_done),
        .fault     (fault)
    );

    int     compared   = 0;
    int     mismatched = 0;
    longint n;

    // model: timestamps of the current sequence and fault episode
    bit     seq_valid;
    longint base;
    longint en [NCH];
    longint end_cyc;
    bit     end_by_stop;
    bit     flt_valid;
    longint flt_from;
    longint flt_to;
    bit     stag_h1, run_h1, run_h2;

    // observations used by the directed literal checks
    longint         rise_at [NCH];
    longint         fall_at [NCH];
    longint         busy_first, busy_last, done_at, fault_rise;
    int             done_cnt;
    logic [NCH-1:0] pwm_prev;
    logic           fault_prev;

    logic [NCH*DLY_W-1:0] dcur;
    longint               s;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NCH*DLY_W-1:0] pk(int d0, int d1, int d2, int d3);
        return {DLY_W'(d3), DLY_W'(d2), DLY_W'(d1), DLY_W'(d0)};
    endfunction

    function automatic longint dly_of(logic [NCH*DLY_W-1:0] d, int k);
        logic [DLY_W-1:0] v;
        v = d[k*DLY_W +: DLY_W];
        return longint'(v);
    endfunction

    function automatic bit stag_at(longint m);
        return seq_valid && m >= base && m < en[NCH-1] && m < end_cyc;
    endfunction

    function automatic bit run_at(longint m);
        return seq_valid && m >= en[NCH-1] && m < end_cyc;
    endfunction

    function automatic bit stop_at(longint m);
        return seq_valid && end_by_stop && m == end_cyc;
    endfunction

    function automatic bit flt_at(longint m);
        return flt_valid && m >= flt_from && m < flt_to;
    endfunction

    function automatic logic [NCH-1:0] pwm_at(longint m);
        logic [NCH-1:0] v;
        v = '0;
        for (int k = 0; k < NCH; k++) begin
            if (seq_valid && m >= en[k] && m < end_cyc) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        seq_valid  = 1'b0;
        flt_valid  = 1'b0;
        stag_h1    = 1'b0;
        run_h1     = 1'b0;
        run_h2     = 1'b0;
        pwm_prev   = '0;
        fault_prev = 1'b0;
    endtask

    task automatic obs_clear();
        for (int k = 0; k < NCH; k++) begin
            rise_at[k] = -1;
            fall_at[k] = -1;
        end
        busy_first = -1;
        busy_last  = -1;
        done_at    = -1;
        fault_rise = -1;
        done_cnt   = 0;
    endtask

    // per-cycle comparison of every output against the model
    task automatic check_cycle(longint m);
        chk($sformatf("pwm_onoff@%0d", m), pwm_onoff, pwm_at(m));
        chk($sformatf("busy@%0d", m), busy, stag_h1);
        chk($sformatf("running@%0d", m), running, run_h1);
        chk($sformatf("seq_done@%0d", m), seq_done, run_h1 && !run_h2);
        chk($sformatf("fault@%0d", m), fault, flt_at(m));
        for (int k = 0; k < NCH; k++) begin
            if (pwm_onoff[k] && !pwm_prev[k]) rise_at[k] = m;
            if (!pwm_onoff[k] && pwm_prev[k]) fall_at[k] = m;
        end
        pwm_prev = pwm_onoff;
        if (busy) begin
            if (busy_first < 0) busy_first = m;
            busy_last = m;
        end
        if (seq_done) begin
            done_cnt++;
            done_at = m;
        end
        if (fault && !fault_prev) fault_rise = m;
        fault_prev = fault;
        run_h2  = run_h1;
        run_h1  = run_at(m);
        stag_h1 = stag_at(m);
    endtask

    // apply the inputs sampled at the end of cycle m
    task automatic model_update(longint m, logic st, logic sp, logic tr, logic fc,
                                logic [NCH*DLY_W-1:0] d);
        bit stg, rn, sto, fl, idl;
        stg = stag_at(m);
        rn  = run_at(m);
        sto = stop_at(m);
        fl  = flt_at(m);
        idl = !(stg || rn || sto || fl);
        if (TRIP_EN && tr) begin
            if (!fl) begin
                flt_valid = 1'b1;
                flt_from  = m + 1;
                flt_to    = INF;
            end
            if (stg || rn) begin
                end_cyc     = m + 1;
                end_by_stop = 1'b0;
            end
        end else if (fl) begin
            if (TRIP_EN && fc) flt_to = m + 1;
        end else if ((stg || rn) && sp) begin
            end_cyc     = m + 1;
            end_by_stop = 1'b1;
        end else if (idl && st && !sp) begin
            seq_valid   = 1'b1;
            base        = m + 1;
            end_cyc     = INF;
            end_by_stop = 1'b0;
            en[0]       = base + dly_of(d, 0) + 1;
            for (int k = 1; k < NCH; k++) en[k] = en[k-1] + dly_of(d, k) + 1;
        end
    endtask

    task automatic cycle(input logic st, input logic sp, input logic tr, input logic fc,
                         input logic [NCH*DLY_W-1:0] d);
        @(posedge clk);
        #1;
        start_req = st;
        stop_req  = sp;
        trip      = tr;
        fault_clr = fc;
        delay     = d;
        @(negedge clk);
        check_cycle(n);
        model_update(n, start_req, stop_req, trip, fault_clr, delay);
        n++;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, dcur);
    endtask

    task automatic stop_and_settle();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, dcur);
        repeat (3) idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        logic st, sp, tr, fc;
        n    = 0;
        dcur = '0;
        model_reset();
        obs_clear();

        // reset state while reset is held low
        #12;
        chk("reset pwm_onoff", pwm_onoff, 0);
        chk("reset busy", busy, 0);
        chk("reset running", running, 0);
        chk("reset seq_done", seq_done, 0);
        chk("reset fault", fault, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) idle();

        // stagger with delays ch0..ch3 = 3,2,0,2
        dcur = pk(3, 2, 0, 2);
        obs_clear();
        s = n;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, dcur);
        repeat (15) idle();
        chk("A ch0 on cycle", rise_at[0] - s, 5);
        chk("A ch1 on cycle", rise_at[1] - s, 8);
        chk("A ch2 on cycle", rise_at[2] - s, 9);
        chk("A ch3 on cycle", rise_at[3] - s, 12);
        chk("A seq_done cycle", done_at - s, 13);
        chk("A busy first", busy_first - s, 2);
        chk("A busy last", busy_last - s, 12);
        // start while running changes nothing
        cycle(1'b1, 1'b0, 1'b0, 1'b0, dcur);
        repeat (3) idle();
        chk("A single seq_done", done_cnt, 1);
        chk("A still running", running, 1);
        chk("A all channels on", pwm_onoff, 4'hF);
        stop_and_settle();

        // stagger with delays ch0..ch3 = 3,2,0,5
        dcur = pk(3, 2, 0, 5);
        obs_clear();
        s = n;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, dcur);
        repeat (20) idle();
        chk("B ch0 on cycle", rise_at[0] - s, 5);
        chk("B ch1 on cycle", rise_at[1] - s, 8);
        chk("B ch2 on cycle", rise_at[2] - s, 9);
        chk("B ch3 on cycle", rise_at[3] - s, 15);
        chk("B seq_done cycle", done_at - s, 16);
        chk("B busy last", busy_last - s, 15);
        stop_and_settle();

        // stop mid-stagger at cycle 7
        obs_clear();
        s = n;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, dcur);
        repeat (6) idle();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, dcur);
        idle();
        chk("C ch1 never on", rise_at[1], -1);
        chk("C ch0 off cycle", fall_at[0] - s, 8);
        chk("C pwm zero", pwm_onoff, 0);
        // back in IDLE at cycle 9: a start there is accepted
        obs_clear();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, dcur);
        repeat (7) idle();
        chk("C restart ch0 on cycle", rise_at[0] - s, 14);
        stop_and_settle();

        // snapshot isolation: delay word changes right after the start
        obs_clear();
        s = n;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, pk(3, 0, 0, 0));
        dcur = pk(100, 100, 100, 100);
        repeat (12) idle();
        chk("D ch0 on cycle", rise_at[0] - s, 5);
        chk("D ch3 on cycle", rise_at[3] - s, 8);
        stop_and_settle();

        // start and stop together in IDLE
        dcur = pk(0, 0, 0, 0);
        obs_clear();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, dcur);
        repeat (4) idle();
        chk("E no busy", busy_first, -1);
        chk("E no channel", rise_at[0], -1);

        // maximum delay value completes
        obs_clear();
        s = n;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, pk(255, 0, 0, 0));
        repeat (262) idle();
        chk("F ch0 on cycle", rise_at[0] - s, 257);
        chk("F ch3 on cycle", rise_at[3] - s, 260);
        chk("F seq_done cycle", done_at - s, 261);
        stop_and_settle();

        // asynchronous reset while running
        dcur = pk(1, 1, 1, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, dcur);
        repeat (12) idle();
        @(posedge clk);
        #3;
        chk("G pwm before reset", pwm_onoff, 4'hF);
        reset = 1'b0;
        #1;
        chk("G pwm cleared async", pwm_onoff, 0);
        chk("G running cleared async", running, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        obs_clear();
        repeat (6) idle();
        chk("G no channel without start", rise_at[0], -1);

`ifdef PWMSEQ_TRIP_EN
        // trip in RUN, start ignored in FAULT, clear only without trip
        dcur = pk(0, 0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, dcur);
        repeat (8) idle();
        obs_clear();
        s = n;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, dcur);
        idle();
        chk("H fault rise", fault_rise - s, 1);
        chk("H ch0 off", fall_at[0] - s, 1);
        obs_clear();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, dcur);
        repeat (3) idle();
        chk("H start ignored in fault", busy_first, -1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, dcur);
        idle();
        chk("H clear with trip ignored", fault, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, dcur);
        idle();
        chk("H fault cleared", fault, 0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom % 4) == 0;
            sp = ($urandom % 20) == 0;
            tr = TRIP_EN && (($urandom % 80) == 0);
            fc = TRIP_EN && (($urandom % 6) == 0);
            if (($urandom % 3) == 0) begin
                dcur = pk($urandom_range(0, 6), $urandom_range(0, 6),
                          $urandom_range(0, 6), $urandom_range(0, 6));
            end
            cycle(st, sp, tr, fc, dcur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
